// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types and constants for the 5-stage pipeline hazard controller.
//   The scoreboard entry struct, the EX operand-forwarding select encoding,
//   and the stage indices of the in-flight scoreboard all live here.
//   The pipeline_hazard_ctrl top and hazard_scoreboard import this package.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Register-id width: 8 general registers, none hardwired to zero.
  localparam int REG_ID_LEN_C = 3;

  // Scoreboard depth and stage positions. Entry 0 mirrors ID/EX, entry 1
  // mirrors EX/MEM and entry 2 mirrors MEM/WB.
  localparam int SB_DEPTH_C = 3;
  localparam int SB_EX      = 0;
  localparam int SB_MEM     = 1;
  localparam int SB_WB      = 2;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                    valid;
    logic [REG_ID_LEN_C-1:0] rd;
    logic                    wr;
    logic                    is_load;
    logic                    wflag;
    logic [REG_ID_LEN_C-1:0] rs1;
    logic [REG_ID_LEN_C-1:0] rs2;
    logic                    uses1;
    logic                    uses2;
  } sb_entry_t;

  // EX operand source select.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,  // value read from the register file in ID
    FWD_EXMEM = 2'd1,  // PR3 ALU result (producer one stage ahead)
    FWD_MEMWB = 2'd2   // PR4 write data (producer two stages ahead)
  } fwd_sel_t;

  // True when entry e will write register r.
  function automatic logic sb_match(input sb_entry_t e,
                                    input logic [REG_ID_LEN_C-1:0] r);
    return e.valid && e.wr && (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Three-entry shift register (EX, MEM, WB) tracking in-flight register and
//   flag writers, plus the per-stage source-register match logic for the
//   instruction currently in ID.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   advance               the ID instruction moves into EX on this edge;
//                         otherwise EX receives a bubble
//   id_rs1, id_rs2        ID source registers
//   id_uses_rs1/2         the corresponding source is actually read
//   id_rd, id_writes_rd   ID destination register and its write enable
//   id_is_load            ID instruction is a memory read
//   id_writes_flags       ID instruction updates C/Z in EX
//   hit_rs1, hit_rs2      per-stage match of each used source (bit index =
//                         SB_EX / SB_MEM / SB_WB); not qualified by id_valid
//   ex_is_load            EX entry is a valid load
//   ex_writes_flags       EX entry is a valid flag writer
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic [REG_ID_LEN_C-1:0] id_rs1,
  input  logic [REG_ID_LEN_C-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [REG_ID_LEN_C-1:0] id_rd,
  input  logic                    id_writes_rd,
  input  logic                    id_is_load,
  input  logic                    id_writes_flags,
  output logic [SB_DEPTH_C-1:0]   hit_rs1,
  output logic [SB_DEPTH_C-1:0]   hit_rs2,
  output logic                    ex_is_load,
  output logic                    ex_writes_flags
);

  sb_entry_t sb_q [SB_DEPTH_C];
  sb_entry_t id_entry;

  // Snapshot of the ID instruction as it would enter EX.
  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = id_rd;
    id_entry.wr      = id_writes_rd;
    id_entry.is_load = id_is_load;
    id_entry.wflag   = id_writes_flags;
    id_entry.rs1     = id_rs1;
    id_entry.rs2     = id_rs2;
    id_entry.uses1   = id_uses_rs1;
    id_entry.uses2   = id_uses_rs2;
  end

  // EX takes the ID instruction or a bubble; older entries simply age.
  // An all-zero entry is invalid, so the bubble is just '0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH_C; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q[SB_EX] <= advance ? id_entry : '0;
      for (int i = 1; i < SB_DEPTH_C; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Per-stage match of each used source operand against the stage's writer.
  // Source fields are kept in each entry for tracing but are not consumed by
  // the hazard equations; the sink below keeps them visibly intentional.
  logic [SB_DEPTH_C-1:0] unused_trace;

  generate
    for (genvar gi = 0; gi < SB_DEPTH_C; gi++) begin : g_match
      assign hit_rs1[gi] = id_uses_rs1 && sb_match(sb_q[gi], id_rs1);
      assign hit_rs2[gi] = id_uses_rs2 && sb_match(sb_q[gi], id_rs2);
      assign unused_trace[gi] = ^{sb_q[gi].rs1, sb_q[gi].rs2,
                                  sb_q[gi].uses1, sb_q[gi].uses2,
                                  sb_q[gi].is_load, sb_q[gi].wflag};
    end
  endgenerate

  // Flags latch at the end of EX, so only the EX entry can hold a pending
  // flag update that a reader in ID would miss.
  assign ex_is_load      = sb_q[SB_EX].valid && sb_q[SB_EX].is_load;
  assign ex_writes_flags = sb_q[SB_EX].valid && sb_q[SB_EX].wflag;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard sequencer for the IF/ID/EX/MEM/WB pipeline. Sits beside the
//   Controller in ID: decode info comes in from ID, load/bubble/flush enables
//   go out to the PC and pipeline registers.
//
//   Build option PIPE_FORWARDING_EN:
//     undefined - full interlock: any RAW on EX/MEM/WB or a flag hazard stalls
//                 (the RF has no write-through, so a WB match stalls too);
//                 fwd_a/fwd_b and id_bypass_a/b are constant 0.
//     defined   - only load-use on EX and flag hazards stall; EX operand
//                 selects are registered as the ID instruction advances and
//                 ID/EX captures WB data directly via id_bypass_a/b.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs1, id_rs2      ID source registers
//   id_uses_rs1/2       corresponding source actually read
//   id_rd               ID destination register
//   id_writes_rd        RF write enable of the ID instruction
//   id_is_load          ID instruction reads memory
//   id_writes_flags     ID instruction updates C/Z in EX
//   id_reads_flags      ID instruction consumes C/Z
//   id_redirect         ID selects a non-PC+1 next PC
//   pc_ld               PC load enable
//   pr1_ld              IF/ID load enable
//   pr1_flush           IF/ID loads a NOP on the next edge
//   pr2_bubble          ID/EX loads a NOP on the next edge
//   fwd_a, fwd_b        registered EX operand selects (fwd_sel_t encoding)
//   id_bypass_a/b       ID/EX captures WB write data for that operand
//   perf_stall_cnt      saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  // Must stay equal to REG_ID_LEN_C: the scoreboard entry layout is fixed.
  parameter int REG_ID_LEN   = REG_ID_LEN_C,
  parameter int PERF_CNT_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ID_LEN-1:0]   id_rs1,
  input  logic [REG_ID_LEN-1:0]   id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [REG_ID_LEN-1:0]   id_rd,
  input  logic                    id_writes_rd,
  input  logic                    id_is_load,
  input  logic                    id_writes_flags,
  input  logic                    id_reads_flags,
  input  logic                    id_redirect,
  output logic                    pc_ld,
  output logic                    pr1_ld,
  output logic                    pr1_flush,
  output logic                    pr2_bubble,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    id_bypass_a,
  output logic                    id_bypass_b,
  output logic [PERF_CNT_LEN-1:0] perf_stall_cnt
);

  logic [SB_DEPTH_C-1:0] hit_rs1;
  logic [SB_DEPTH_C-1:0] hit_rs2;
  logic                  ex_is_load;
  logic                  ex_writes_flags;
  logic                  raw_ex;
  logic                  raw_mem;
  logic                  raw_wb;
  logic                  flag_hazard;
  logic                  stall;
  logic                  advance;

  hazard_scoreboard u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .id_writes_flags (id_writes_flags),
    .hit_rs1         (hit_rs1),
    .hit_rs2         (hit_rs2),
    .ex_is_load      (ex_is_load),
    .ex_writes_flags (ex_writes_flags)
  );

  // RAW hazards of the ID instruction against each in-flight stage.
  assign raw_ex  = id_valid && (hit_rs1[SB_EX]  || hit_rs2[SB_EX]);
  assign raw_mem = id_valid && (hit_rs1[SB_MEM] || hit_rs2[SB_MEM]);
  assign raw_wb  = id_valid && (hit_rs1[SB_WB]  || hit_rs2[SB_WB]);

  assign flag_hazard = id_valid && id_reads_flags && ex_writes_flags;

`ifdef PIPE_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; MEM/WB producers are
  // reached through fwd_a/fwd_b and id_bypass_a/b respectively.
  assign stall = (raw_ex && ex_is_load) || flag_hazard;
`else
  // No forwarding and no RF write-through: wait until the producer retires.
  assign stall = raw_ex || raw_mem || raw_wb || flag_hazard;
`endif

  assign advance = id_valid && !stall;

  // Pipeline register controls. Stall freezes PC and IF/ID and injects a
  // bubble into ID/EX. A redirect is only honoured once ID actually
  // advances; IF/ID is then flushed to kill the fall-through fetch. The
  // stalled instruction is re-evaluated each cycle, so nothing is latched.
  always_comb begin
    pc_ld      = 1'b1;
    pr1_ld     = 1'b1;
    pr2_bubble = 1'b0;
    pr1_flush  = 1'b0;
    if (stall) begin
      pc_ld      = 1'b0;
      pr1_ld     = 1'b0;
      pr2_bubble = 1'b1;
    end else begin
      pr1_flush  = id_valid && id_redirect;
    end
  end

`ifdef PIPE_FORWARDING_EN
  fwd_sel_t fwd_a_q;
  fwd_sel_t fwd_b_q;
  fwd_sel_t fwd_a_next;
  fwd_sel_t fwd_b_next;

  // Youngest producer wins: EX (one ahead) before MEM (two ahead). A bubble
  // entering EX carries no operands, so the selects fall back to the RF.
  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (advance) begin
      if (hit_rs1[SB_EX])       fwd_a_next = FWD_EXMEM;
      else if (hit_rs1[SB_MEM]) fwd_a_next = FWD_MEMWB;
      if (hit_rs2[SB_EX])       fwd_b_next = FWD_EXMEM;
      else if (hit_rs2[SB_MEM]) fwd_b_next = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_next;
      fwd_b_q <= fwd_b_next;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

  // WB data is written this same cycle; steer it straight into ID/EX
  // because the RF read in ID would still return the stale value.
  assign id_bypass_a = id_valid && hit_rs1[SB_WB];
  assign id_bypass_b = id_valid && hit_rs2[SB_WB];
`else
  logic unused_ex_is_load;

  assign fwd_a       = FWD_RF;
  assign fwd_b       = FWD_RF;
  assign id_bypass_a = 1'b0;
  assign id_bypass_b = 1'b0;
  // Load-ness only matters when forwarding can hide ALU results.
  assign unused_ex_is_load = ex_is_load;
`endif

  // Stall-cycle counter, saturating at all-ones.
  logic [PERF_CNT_LEN-1:0] perf_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt_reg <= '0;
    end else if (stall && (perf_cnt_reg != {PERF_CNT_LEN{1'b1}})) begin
      perf_cnt_reg <= perf_cnt_reg + PERF_CNT_LEN'(1);
    end
  end

  assign perf_stall_cnt = perf_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. A driver applies one ID
//   instruction per cycle and queues the hand-computed expected controls; a
//   monitor pops and compares at the falling edge (or on demand for the
//   asynchronous reset checks). Expectations follow PIPE_FORWARDING_EN.
//   A 4-bit stall counter is used so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
`ifdef PIPE_FORWARDING_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [2:0]    id_rs1;
  logic [2:0]    id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [2:0]    id_rd;
  logic          id_writes_rd;
  logic          id_is_load;
  logic          id_writes_flags;
  logic          id_reads_flags;
  logic          id_redirect;
  logic          pc_ld;
  logic          pr1_ld;
  logic          pr1_flush;
  logic          pr2_bubble;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          id_bypass_a;
  logic          id_bypass_b;
  logic [CW-1:0] perf_stall_cnt;

  pipeline_hazard_ctrl #(.REG_ID_LEN(3), .PERF_CNT_LEN(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .id_writes_flags (id_writes_flags),
    .id_reads_flags  (id_reads_flags),
    .id_redirect     (id_redirect),
    .pc_ld           (pc_ld),
    .pr1_ld          (pr1_ld),
    .pr1_flush       (pr1_flush),
    .pr2_bubble      (pr2_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .id_bypass_a     (id_bypass_a),
    .id_bypass_b     (id_bypass_b),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       wr;
    logic [2:0] rs1;
    logic       u1;
    logic [2:0] rs2;
    logic       u2;
    logic       ld;
    logic       wf;
    logic       rf;
    logic       redir;
  } ins_t;

  typedef struct {
    string         name;
    logic          stall;
    logic          flush;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          ba;
    logic          bb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  event          sample_ev;
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] model_cnt = '0;

  function automatic ins_t mk(input logic [2:0] rd, input logic wr,
                              input logic [2:0] rs1, input logic u1,
                              input logic [2:0] rs2, input logic u2,
                              input logic ld, input logic wf,
                              input logic rf, input logic redir);
    ins_t i;
    i = '{1'b1, rd, wr, rs1, u1, rs2, u2, ld, wf, rf, redir};
    return i;
  endfunction

  task automatic drive(input ins_t i);
    id_valid        = i.valid;
    id_rd           = i.rd;
    id_writes_rd    = i.wr;
    id_rs1          = i.rs1;
    id_uses_rs1     = i.u1;
    id_rs2          = i.rs2;
    id_uses_rs2     = i.u2;
    id_is_load      = i.ld;
    id_writes_flags = i.wf;
    id_reads_flags  = i.rf;
    id_redirect     = i.redir;
  endtask

  function automatic exp_t mk_exp(input string nm, input logic st,
                                  input logic fl, input logic [1:0] fa,
                                  input logic [1:0] fb, input logic ba,
                                  input logic bb);
    exp_t e;
    e.name = nm; e.stall = st; e.flush = fl;
    e.fa = fa; e.fb = fb; e.ba = ba; e.bb = bb;
    e.cnt = model_cnt;
    return e;
  endfunction

  // One clock of stimulus: present i in ID and queue the expected response.
  task automatic step(input string nm, input ins_t i, input logic st,
                      input logic fl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic ba, input logic bb);
    @(posedge clk);
    #1;
    drive(i);
    exp_q.push_back(mk_exp(nm, st, fl, fa, fb, ba, bb));
    if (st && model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic idle(input int n);
    ins_t nop;
    nop = '0;
    for (int k = 0; k < n; k++) step("nop", nop, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc_ld",      8'(pc_ld),          8'(!e.stall));
        chk(e.name, "pr1_ld",     8'(pr1_ld),         8'(!e.stall));
        chk(e.name, "pr2_bubble", 8'(pr2_bubble),     8'(e.stall));
        chk(e.name, "pr1_flush",  8'(pr1_flush),      8'(e.flush));
        chk(e.name, "fwd_a",      8'(fwd_a),          8'(e.fa));
        chk(e.name, "fwd_b",      8'(fwd_b),          8'(e.fb));
        chk(e.name, "bypass_a",   8'(id_bypass_a),    8'(e.ba));
        chk(e.name, "bypass_b",   8'(id_bypass_b),    8'(e.bb));
        chk(e.name, "stall_cnt",  8'(perf_stall_cnt), 8'(e.cnt));
        $display("txn %-10s pc_ld=%b bubble=%b flush=%b fwd=%0d/%0d byp=%b%b cnt=%0d",
                 e.name, pc_ld, pr2_bubble, pr1_flush, fwd_a, fwd_b,
                 id_bypass_a, id_bypass_b, perf_stall_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, a1, a2, ld3, a4, jmp, jinv, a5, jr, cmp, brc, ld1, adc;
    nop  = '0;
    a1   = mk(3'd1, 1, 3'd5, 1, 3'd6, 1, 0, 0, 0, 0); // ADD r1,r5,r6
    a2   = mk(3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0, 0); // ADD r2,r1,r3
    ld3  = mk(3'd3, 1, 3'd7, 1, 3'd0, 0, 1, 0, 0, 0); // LOAD r3,[r7]
    a4   = mk(3'd4, 1, 3'd3, 1, 3'd3, 1, 0, 0, 0, 0); // ADD r4,r3,r3
    jmp  = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1); // JMP imm
    jinv = jmp; jinv.valid = 1'b0;
    a5   = mk(3'd5, 1, 3'd6, 1, 3'd6, 1, 0, 0, 0, 0); // ADD r5,r6,r6
    jr   = mk(3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0, 0, 1); // JMP r5
    cmp  = mk(3'd0, 0, 3'd1, 1, 3'd2, 1, 0, 1, 0, 0); // CMP r1,r2
    brc  = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 1); // BRC taken
    ld1  = mk(3'd1, 1, 3'd7, 1, 3'd0, 0, 1, 0, 0, 0); // LOAD r1,[r7]
    adc  = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 0); // flag read+write

    // Reset state, with an instruction already in ID.
    rst = 1'b0;
    drive(a2);
    #12;
    exp_q.push_back(mk_exp("reset", 0, 0, 0, 0, 0, 0));
    ->sample_ev;
    @(negedge clk);
    rst = 1'b1;

    // ADD r1 then dependent ADD.
    step("s1_add1", a1, 0, 0, 0, 0, 0, 0);
    if (!F) begin
      repeat (3) step("s1_stall", a2, 1, 0, 0, 0, 0, 0);
      step("s1_issue", a2, 0, 0, 0, 0, 0, 0);
      step("s1_ex", nop, 0, 0, 0, 0, 0, 0);
    end else begin
      step("s1_issue", a2, 0, 0, 0, 0, 0, 0);
      step("s1_ex", nop, 0, 0, 2'd1, 0, 0, 0);
    end
    idle(3);

    // Producer already in WB.
    step("s1b_add1", a1, 0, 0, 0, 0, 0, 0);
    idle(2);
    if (!F) begin
      step("s1b_stall", a2, 1, 0, 0, 0, 0, 0);
      step("s1b_issue", a2, 0, 0, 0, 0, 0, 0);
    end else begin
      step("s1b_byp", a2, 0, 0, 0, 0, 1, 0);
    end
    idle(3);

    // Load-use.
    step("s3_load", ld3, 0, 0, 0, 0, 0, 0);
    step("s3_stall", a4, 1, 0, 0, 0, 0, 0);
    if (!F) begin
      repeat (2) step("s3_stall", a4, 1, 0, 0, 0, 0, 0);
      step("s3_issue", a4, 0, 0, 0, 0, 0, 0);
      step("s3_ex", nop, 0, 0, 0, 0, 0, 0);
    end else begin
      step("s3_issue", a4, 0, 0, 0, 0, 0, 0);
      step("s3_ex", nop, 0, 0, 2'd2, 2'd2, 0, 0);
    end
    idle(3);

    // Redirects.
    step("s4_jmp", jmp, 0, 1, 0, 0, 0, 0);
    step("s4_after", nop, 0, 0, 0, 0, 0, 0);
    step("s4_jinv", jinv, 0, 0, 0, 0, 0, 0);
    step("s4_add5", a5, 0, 0, 0, 0, 0, 0);
    if (!F) begin
      repeat (3) step("s4_jr_st", jr, 1, 0, 0, 0, 0, 0);
      step("s4_jr_go", jr, 0, 1, 0, 0, 0, 0);
      step("s4_after", nop, 0, 0, 0, 0, 0, 0);
    end else begin
      step("s4_jr_go", jr, 0, 1, 0, 0, 0, 0);
      step("s4_after", nop, 0, 0, 2'd1, 0, 0, 0);
    end
    idle(3);

    // Flag hazard with a taken branch behind it.
    step("s5_cmp", cmp, 0, 0, 0, 0, 0, 0);
    step("s5_brc_st", brc, 1, 0, 0, 0, 0, 0);
    step("s5_brc_go", brc, 0, 1, 0, 0, 0, 0);
    step("s5_after", nop, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset in the middle of a stall.
    step("s6_load", ld1, 0, 0, 0, 0, 0, 0);
    step("s6_stall1", a2, 1, 0, 0, 0, 0, 0);
    if (!F) step("s6_stall2", a2, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_cnt = '0;
    exp_q.push_back(mk_exp("s6_rst", 0, 0, 0, 0, 0, 0));
    ->sample_ev;
    @(posedge clk);
    #3;
    rst = 1'b1;
    idle(3);

    // Saturation of the stall counter.
    step("s7_adc", adc, 0, 0, 0, 0, 0, 0);
    repeat (20) begin
      step("s7_st", adc, 1, 0, 0, 0, 0, 0);
      step("s7_go", adc, 0, 0, 0, 0, 0, 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline (IF, ID, EX, MEM, WB) that has no hazard handling today.
- Tracks in-flight register and flag writers in a scoreboard.
- Drives the PC/IF-ID load enables, ID/EX bubble insertion and IF-ID flush on redirects.
- Optionally drives operand forwarding selects.
- Sits beside the Controller in stage 1; all decode info comes from ID, all outputs go to the PC and pipeline registers.

Parameters:
- REG_ID_LEN, 3, register-id width (8 registers, none hardwired to zero).
- PERF_CNT_LEN, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ID_LEN  ID first source register (instruction[10:8]).
- id_rs2  in  REG_ID_LEN  ID second source register (already muxed).
- id_uses_rs1, id_uses_rs2  in  1 each  source actually read.
- id_rd  in  REG_ID_LEN  ID destination register (instruction[13:11]).
- id_writes_rd  in  1  RF_write_en of the ID instruction.
- id_is_load  in  1  MEM_read of the ID instruction.
- id_writes_flags  in  1  ID instruction updates C/Z in EX.
- id_reads_flags  in  1  ID instruction consumes C/Z (conditional branch, ADC/SBC).
- id_redirect  in  1  ID selects a non-PC+1 next PC (jump, taken branch, call, ret).
- pc_ld  out  1  PC load enable.
- pr1_ld  out  1  IF/ID load enable.
- pr1_flush  out  1  IF/ID loads a NOP on the next edge.
- pr2_bubble  out  1  ID/EX loads a NOP on the next edge; controls forced 0.
- fwd_a, fwd_b  out  2 each  EX operand select (FORWARDING_EN only; else tied 0).
- id_bypass_a, id_bypass_b  out  1 each  ID/EX captures WB write data (FORWARDING_EN only; else 0).
- perf_stall_cnt  out  PERF_CNT_LEN  count of stall cycles.

Behaviour:
- Scoreboard: entries EX, MEM, WB; each entry holds {valid, rd, wr, is_load, wflag, rs1, rs2, uses1, uses2}.
  - Each edge: WB <= MEM, MEM <= EX.
  - EX <= ID fields when id_valid && !stall; otherwise EX <= invalid (the bubble).
- match(r, S) = S.valid && S.wr && S.rd == r.
- raw_hazard(S) = id_valid && ((id_uses_rs1 && match(id_rs1, S)) || (id_uses_rs2 && match(id_rs2, S))).
- flag_hazard = id_valid && id_reads_flags && EX.valid && EX.wflag. Flags latch at the end of EX.
- Stall without FORWARDING_EN:
  - stall = raw_hazard on any of EX, MEM, WB, or flag_hazard.
  - The RF has no write-through bypass, so a WB match stalls too.
  - Back-to-back dependency costs 3 cycles.
- On stall (combinational, same cycle): pc_ld=0, pr1_ld=0, pr2_bubble=1, pr1_flush=0. Otherwise pc_ld=1, pr1_ld=1, pr2_bubble=0.
- Redirect:
  - pr1_flush = id_redirect && id_valid && !stall. It is one cycle and kills the IF instruction fetched behind the redirect.
  - A redirect under stall is held off until the stall clears. The ID instruction is re-evaluated each cycle, so no latch is needed.
- Stall has priority over flush; they are never asserted together.
- perf_stall_cnt: +1 on each edge where stall=1; saturates at all-ones; no wrap.
- Reset (asynchronous): all scoreboard entries invalid, fwd registers 0, counter 0. Outputs then evaluate to pc_ld=1, pr1_ld=1, pr1_flush=0, pr2_bubble=0, bypass 0. Reset mid-stall drops the stall immediately.
- Outputs are combinational from the scoreboard plus ID inputs; fwd_a/fwd_b are registered.

Optional Feature:
- PIPE_FORWARDING_EN defined:
  - stall = (raw_hazard(EX) && EX.is_load) || flag_hazard.
  - fwd_a/fwd_b are registered when the ID instruction advances; per operand, youngest producer wins:
    - EX match -> 1 (PR3 ALU out).
    - else MEM match -> 2 (PR4 write data).
    - else 0.
  - id_bypass_a/b = WB match on that operand, same cycle.
  - Load-use costs 1 stall, then fwd=2.
- Undefined: fwd/bypass are constant 0; full-interlock stall as above.

Decomposition:
- pipe_ctrl_pkg holds:
  - REG_ID_LEN_C;
  - sb_entry_t struct;
  - fwd_sel_t enum: FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
- One sub-module, hazard_scoreboard: the 3-entry shift register plus match logic. The top holds stall, flush, forwarding and the counter.

Test Plan:
1. ADD r1 then ADD r2,r1,r3, no forwarding -> pc_ld=0 and pr2_bubble=1 for exactly 3 cycles, then the ADD issues; perf_stall_cnt=3.
2. Same sequence with PIPE_FORWARDING_EN -> 0 stalls; fwd_a=1 while the second ADD is in EX.
3. LOAD r3 then ADD r4,r3,r3 with forwarding -> 1 stall cycle, then fwd_a=fwd_b=2; counter=1.
4. JMP in ID -> pr1_flush=1 for one cycle, pc_ld=1. JMP whose operand is stalled by an ADD in EX -> pr1_flush only in the first non-stall cycle.
5. CMP (writes flags) then BRC (reads flags) -> 1 stall; BRC issues when CMP reaches MEM.
6. Assert rst low during stall 2 of 3 -> pc_ld=1 and pr2_bubble=0 without waiting for a clock edge; counter=0; entries invalid. Force the counter to all-ones, stall once -> stays all-ones.
